// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the pipelined ALU.
//   alu_op_t    - 3-bit operation select carried on cntrl
//   alu_flags_t - packed {n, z, v, c} condition flags
package alu_pkg;

    typedef enum logic [2:0] {
        OP_PASSB = 3'b000,
        OP_LSL   = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_AND   = 3'b100,
        OP_OR    = 3'b101,
        OP_XOR   = 3'b110,
        OP_LSR   = 3'b111
    } alu_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational WIDTH-bit ALU datapath.
//   a_i, b_i  in  WIDTH  operands
//   shamt_i   in  SHW    shift amount for LSL/LSR
//   op_i      in  op     operation select
//   result_o  out WIDTH  result, mod 2^WIDTH
//   flags_o   out 4      {N,Z,V,C} of result_o
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [SHW-1:0]   shamt_i,
    input  alu_op_t          op_i,
    output logic [WIDTH-1:0] result_o,
    output alu_flags_t       flags_o
);

    logic             sub;
    logic             arith;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    // Subtract reuses the adder as A + ~B + 1, so C=1 means no borrow.
    assign sub   = op_i == OP_SUB;
    assign arith = (op_i == OP_ADD) | sub;
    assign b_eff = sub ? ~b_i : b_i;
    assign sum   = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

    always_comb begin
        case (op_i)
            OP_LSL:  result_o = a_i << shamt_i;
            OP_ADD:  result_o = sum[WIDTH-1:0];
            OP_SUB:  result_o = sum[WIDTH-1:0];
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_LSR:  result_o = a_i >> shamt_i;
            default: result_o = b_i;
        endcase
        flags_o.n = result_o[WIDTH-1];
        flags_o.z = ~|result_o;
        flags_o.c = arith & sum[WIDTH];
        // Overflow: effective operands share a sign that the sum does not.
        flags_o.v = arith & (a_i[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != a_i[WIDTH-1]);
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes and an
// architectural NZVC flag register.
//   clk, reset_n          clock, synchronous active-low reset
//   in_valid / in_ready   operation handshake (a, b, shamt, cntrl, set_flags)
//   out_valid / out_ready result handshake (result, res_flags)
//   flags                 architectural {N,Z,V,C}, loaded when a set_flags op retires
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    input  logic [2:0]       cntrl,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       res_flags,
    output logic [3:0]       flags
);

    logic             adv1;
    logic             adv2;
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [SHW-1:0]   s1_shamt_q;
    alu_op_t          s1_op_q;
    logic             s1_setf_q;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_result_q;
    alu_flags_t       s2_flags_q;
    logic             s2_setf_q;
    alu_flags_t       flags_q, flags_d;
    logic [WIDTH-1:0] core_result;
    alu_flags_t       core_flags;

    // A stage may load when it is empty or its contents move on this edge.
    assign adv2     = ~s2_valid_q | out_ready;
    assign adv1     = ~s1_valid_q | adv2;
    assign in_ready = adv1;

    assign s1_valid_d = adv1 ? in_valid : s1_valid_q;
    assign s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
    assign flags_d    = (s2_valid_q & out_ready & s2_setf_q) ? s2_flags_q : flags_q;

    alu_core #(.WIDTH(WIDTH), .SHW(SHW)) u_core (
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .shamt_i  (s1_shamt_q),
        .op_i     (s1_op_q),
        .result_o (core_result),
        .flags_o  (core_flags)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_shamt_q  <= '0;
            s1_op_q     <= OP_PASSB;
            s1_setf_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_flags_q  <= '0;
            s2_setf_q   <= 1'b0;
            flags_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            flags_q    <= flags_d;
            if (in_valid & adv1) begin
                s1_a_q     <= a;
                s1_b_q     <= b;
                s1_shamt_q <= shamt;
                s1_op_q    <= alu_op_t'(cntrl);
                s1_setf_q  <= set_flags;
            end
            if (s1_valid_q & adv2) begin
                s2_result_q <= core_result;
                s2_flags_q  <= core_flags;
                s2_setf_q   <= s1_setf_q;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = s2_result_q;
    assign res_flags = s2_flags_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: randomized and directed checks of alu_pipe against a queue-based reference model.
module tb_alu_pipe;

    typedef struct {
        int          k;
        logic [63:0] r;
        logic [3:0]  f;
        logic        sf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic [5:0]  shamt;
    logic [2:0]  cntrl;
    logic        set_flags;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic [3:0]  res_flags;
    logic [3:0]  flags;

    exp_t        q[$];
    logic [3:0]  mflags;
    logic [63:0] last_r;
    logic [3:0]  last_f;
    int          cyc;
    int          n_ret;
    int          n_cmp;
    int          n_err;

    alu_pipe #(.WIDTH(64)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .shamt     (shamt),
        .cntrl     (cntrl),
        .set_flags (set_flags),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .res_flags (res_flags),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: {N,Z,V,C, result} from plain arithmetic on the operation definitions.
    function automatic logic [67:0] ref_op(input logic [63:0] x, input logic [63:0] y,
                                           input logic [5:0] sh, input logic [2:0] op);
        logic [63:0]        r;
        logic [64:0]        w;
        logic signed [64:0] s;
        logic               v;
        logic               c;
        v = 1'b0;
        c = 1'b0;
        case (op)
            3'd0: r = y;
            3'd1: r = x << sh;
            3'd2: begin
                r = x + y;
                w = {1'b0, x} + {1'b0, y};
                c = w[64];
                s = $signed({x[63], x}) + $signed({y[63], y});
                v = s[64] != s[63];
            end
            3'd3: begin
                r = x - y;
                c = x >= y;
                s = $signed({x[63], x}) - $signed({y[63], y});
                v = s[64] != s[63];
            end
            3'd4: r = x & y;
            3'd5: r = x | y;
            3'd6: r = x ^ y;
            default: r = x >> sh;
        endcase
        return {r[63], r == 64'd0, v, c, r};
    endfunction

    task automatic step(input logic iv, input logic [63:0] ia, input logic [63:0] ib,
                        input logic [5:0] ish, input logic [2:0] iop, input logic isf,
                        input logic ordy, output logic acc);
        exp_t        e;
        logic [67:0] m;
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        shamt     = ish;
        cntrl     = iop;
        set_flags = isf;
        out_ready = ordy;
        #1;
        check("in_ready", in_ready, !(q.size() == 2 && !ordy));
        check("out_valid", out_valid, q.size() > 0 && q[0].k + 1 <= cyc);
        if (out_valid && q.size() > 0) begin
            check("result", result, q[0].r);
            check("res_flags", res_flags, q[0].f);
            if (ordy) begin
                last_r = result;
                last_f = res_flags;
                if (q[0].sf) mflags = q[0].f;
                void'(q.pop_front());
                n_ret++;
            end
        end
        acc = iv && in_ready;
        if (acc) begin
            m    = ref_op(ia, ib, ish, iop);
            e.k  = cyc + 1;
            e.r  = m[63:0];
            e.f  = m[67:64];
            e.sf = isf;
            q.push_back(e);
        end
        @(posedge clk);
        cyc++;
        #1 check("flags", flags, mflags);
    endtask

    task automatic one(input logic [63:0] ia, input logic [63:0] ib, input logic [5:0] ish,
                       input logic [2:0] iop, input logic isf);
        logic acc;
        step(1'b1, ia, ib, ish, iop, isf, 1'b1, acc);
        step(1'b0, '0, '0, '0, 3'd0, 1'b0, 1'b1, acc);
        step(1'b0, '0, '0, '0, 3'd0, 1'b0, 1'b1, acc);
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            @(negedge clk);
            reset_n   = 1'b0;
            in_valid  = 1'b1;
            a         = {$urandom, $urandom};
            b         = {$urandom, $urandom};
            cntrl     = 3'd2;
            set_flags = 1'b1;
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            cyc++;
        end
        q.delete();
        mflags = 4'd0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_flags", flags, 0);
        check("rst_result", result, 0);
        check("rst_res_flags", res_flags, 0);
        @(negedge clk);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        cyc++;
        #1 check("rst_in_ready", in_ready, 1);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h7FFF_FFFF_FFFF_FFFF;
            4: return 64'($urandom_range(0, 7));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        acc;
        logic [63:0] oa[6];
        logic [63:0] ob[6];
        logic [2:0]  oo[6];
        int          issued;
        int          c;
        n_cmp = 0; n_err = 0; cyc = 0; n_ret = 0;
        mflags = 4'd0; last_r = '0; last_f = '0;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; shamt = '0; cntrl = '0; set_flags = 1'b0;

        do_reset(3);

        one(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 3'd2, 1'b1);
        check("add_res", last_r, 64'h8000_0000_0000_0000);
        check("add_nzvc", last_f, 4'b1010);
        check("add_flags", flags, 4'b1010);

        one(64'd5, 64'd5, 6'd0, 3'd3, 1'b1);
        check("sub0_res", last_r, 64'd0);
        check("sub0_nzvc", last_f, 4'b0101);
        one(64'd0, 64'd1, 6'd0, 3'd3, 1'b0);
        check("subneg_res", last_r, '1);
        check("subneg_nzvc", last_f, 4'b1000);
        check("subneg_flags", flags, 4'b0101);

        one(64'd1, 64'd0, 6'd63, 3'd1, 1'b0);
        check("lsl63", last_r, 64'h8000_0000_0000_0000);
        one(64'd1, 64'd0, 6'd0, 3'd7, 1'b0);
        check("lsr0", last_r, 64'd1);
        one(64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 6'd0, 3'd4, 1'b0);
        check("and", last_r, 64'hF000_F000_F000_F000);
        one(64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 6'd0, 3'd5, 1'b0);
        check("or", last_r, 64'hFFF0_FFF0_FFF0_FFF0);
        one(64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 6'd0, 3'd6, 1'b0);
        check("xor", last_r, 64'h0FF0_0FF0_0FF0_0FF0);

        // Back-pressure: six back-to-back ops, consumer stalls on cycles 3-6.
        for (int i = 0; i < 6; i++) begin
            oa[i] = {$urandom, $urandom};
            ob[i] = {$urandom, $urandom};
            oo[i] = 3'($urandom_range(0, 7));
        end
        issued = 0;
        n_ret  = 0;
        c      = 1;
        while ((issued < 6 || q.size() > 0) && c < 40) begin
            if (issued < 6) step(1'b1, oa[issued], ob[issued], 6'(c), oo[issued], 1'b0, !(c >= 3 && c <= 6), acc);
            else step(1'b0, '0, '0, '0, 3'd0, 1'b0, 1'b1, acc);
            if (acc) issued++;
            c++;
        end
        check("bp_retired", n_ret, 6);
        check("bp_drained", q.size(), 0);

        // Reset with two ops in flight: both discarded, flags untouched.
        step(1'b1, 64'd3, 64'd4, 6'd0, 3'd2, 1'b1, 1'b0, acc);
        step(1'b1, '1, '1, 6'd0, 3'd2, 1'b1, 1'b0, acc);
        check("mid_inflight", q.size(), 2);
        do_reset(1);
        one(64'd2, 64'd3, 6'd0, 3'd2, 1'b0);
        check("post_rst_res", last_r, 64'd5);
        check("post_rst_flags", flags, 0);

        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), pick(), pick(), 6'($urandom_range(0, 63)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), acc);
        for (int i = 0; i < 10 && q.size() > 0; i++)
            step(1'b0, '0, '0, '0, 3'd0, 1'b0, 1'b1, acc);
        check("final_drain", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
